// File: rtl/fifo_push_arb.sv
// Two-requester round-robin push arbiter in front of a FIFO, with a flush/recover sequencer.
// Define FIFO_PUSH_ARB_STATS_EN to build the saturating Push_Count/Stall_Count statistics.
module fifo_push_arb #(
  parameter int DATA_WIDTH   = 18,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Req0,
  input  logic [DATA_WIDTH-1:0] Din0,
  output logic                  Gnt0,
  input  logic                  Req1,
  input  logic [DATA_WIDTH-1:0] Din1,
  output logic                  Gnt1,
  input  logic                  Flush_Req,
  output logic                  Flush_Done,
  output logic                  Busy,
  output logic                  PUSH,
  output logic [DATA_WIDTH-1:0] DIN,
  output logic                  Fifo_Push_Flush,
  input  logic [3:0]            PUSH_FLAG,
  input  logic                  Almost_Full,
  output logic [15:0]           Push_Count,
  output logic [15:0]           Stall_Count
);

  typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt, cnt_nxt;
  logic                  rr_ptr;   // 1 = requester 1 wins the next tie
  logic                  push_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  done_q, done_nxt;
  logic                  space, gnt0, gnt1;

  // Almost_Full lags the push just made, so a push last cycle consumes the final slot.
  assign space = (PUSH_FLAG != 4'h0) && !(Almost_Full && push_q);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      RUN: begin
        if (Flush_Req) begin
          state_nxt = FLUSH;
          cnt_nxt   = 4'd0;
        end else if (space) begin
          gnt0 = Req0 && (!Req1 || !rr_ptr);
          gnt1 = Req1 && (!Req0 || rr_ptr);
        end
      end
      FLUSH: begin
        if (cnt == 4'(FLUSH_CYCLES - 1)) begin
          state_nxt = RECOVER;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      RECOVER: begin
        if (cnt == 4'd1) begin
          state_nxt = RUN;
          cnt_nxt   = 4'd0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= RUN;
      cnt    <= 4'd0;
      rr_ptr <= 1'b0;
      push_q <= 1'b0;
      din_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      push_q <= gnt0 | gnt1;
      done_q <= done_nxt;
      if (gnt0) begin
        rr_ptr <= 1'b1;
        din_q  <= Din0;
      end else if (gnt1) begin
        rr_ptr <= 1'b0;
        din_q  <= Din1;
      end
    end
  end

  // Grants are combinational, so gate them with reset to keep them quiet while held in reset.
  assign Gnt0            = gnt0 & Rst_n;
  assign Gnt1            = gnt1 & Rst_n;
  assign PUSH            = push_q;
  assign DIN             = din_q;
  assign Flush_Done      = done_q;
  assign Busy            = (state != RUN);
  assign Fifo_Push_Flush = (state == FLUSH);

`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [15:0] push_cnt, stall_cnt;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      push_cnt  <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (push_q && push_cnt != 16'hFFFF)
        push_cnt <= push_cnt + 16'd1;
      if (state == RUN && (Req0 || Req1) && !(gnt0 || gnt1) && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign Push_Count  = push_cnt;
  assign Stall_Count = stall_cnt;
`else
  assign Push_Count  = 16'd0;
  assign Stall_Count = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_push_arb.sv
// Directed table-driven bench for fifo_push_arb plus hand sequences for reset-in-flush and statistics.
module tb_fifo_push_arb;
  localparam int DW = 18;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic          Req0, Req1, Gnt0, Gnt1;
  logic [DW-1:0] Din0, Din1, DIN;
  logic          Flush_Req, Flush_Done, Busy, PUSH, Fifo_Push_Flush, Almost_Full;
  logic [3:0]    PUSH_FLAG;
  logic [15:0]   Push_Count, Stall_Count;

  int checks = 0;
  int errors = 0;

  fifo_push_arb #(.DATA_WIDTH(DW), .FLUSH_CYCLES(4)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req0(Req0), .Din0(Din0), .Gnt0(Gnt0),
    .Req1(Req1), .Din1(Din1), .Gnt1(Gnt1),
    .Flush_Req(Flush_Req), .Flush_Done(Flush_Done), .Busy(Busy),
    .PUSH(PUSH), .DIN(DIN), .Fifo_Push_Flush(Fifo_Push_Flush),
    .PUSH_FLAG(PUSH_FLAG), .Almost_Full(Almost_Full),
    .Push_Count(Push_Count), .Stall_Count(Stall_Count)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic          r0, r1;
    logic [DW-1:0] d0, d1;
    logic [3:0]    flag;
    logic          af, fl;
    logic          g0, g1, push;
    logic [DW-1:0] din;
    logic          busy, fpf, done;
  } vec_t;

  vec_t vec [29];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r0, r1, input logic [DW-1:0] d0, d1,
                              input logic [3:0] flag, input logic af, fl,
                              input logic g0, g1, push, input logic [DW-1:0] din,
                              input logic busy, fpf, done);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.flag = flag; v.af = af; v.fl = fl;
    v.g0 = g0; v.g1 = g1; v.push = push; v.din = din; v.busy = busy; v.fpf = fpf; v.done = done;
    return v;
  endfunction

  task automatic idle_inputs();
    Req0 = 0; Req1 = 0; Din0 = '0; Din1 = '0; Flush_Req = 0; PUSH_FLAG = 4'h8; Almost_Full = 0;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Rst_n = 0;
    @(negedge Clk);
    Rst_n = 1;
  endtask

  initial begin
    int n;
    logic [15:0] exp_stall, exp_push;
    //             r0 r1 d0        d1        flag  af fl  g0 g1 pu din       bz fpf dn
    vec[0]  = mk(1, 0, 18'h00A01, 18'h0,     4'h8, 0, 0,  1, 0, 0, 18'h0,     0, 0, 0);
    vec[1]  = mk(1, 0, 18'h00A02, 18'h0,     4'h8, 0, 0,  1, 0, 1, 18'h00A01, 0, 0, 0);
    vec[2]  = mk(1, 0, 18'h00A03, 18'h0,     4'h8, 0, 0,  1, 0, 1, 18'h00A02, 0, 0, 0);
    vec[3]  = mk(1, 0, 18'h00A04, 18'h0,     4'h8, 0, 0,  1, 0, 1, 18'h00A03, 0, 0, 0);
    vec[4]  = mk(0, 0, 18'h0,     18'h0,     4'h8, 0, 0,  0, 0, 1, 18'h00A04, 0, 0, 0);
    vec[5]  = mk(0, 0, 18'h0,     18'h0,     4'h8, 0, 0,  0, 0, 0, 18'h00A04, 0, 0, 0);
    // last grant went to 0, so the first tie goes to 1
    vec[6]  = mk(1, 1, 18'h00B00, 18'h00C00, 4'h8, 0, 0,  0, 1, 0, 18'h00A04, 0, 0, 0);
    vec[7]  = mk(1, 1, 18'h00B00, 18'h00C01, 4'h8, 0, 0,  1, 0, 1, 18'h00C00, 0, 0, 0);
    vec[8]  = mk(1, 1, 18'h00B01, 18'h00C01, 4'h8, 0, 0,  0, 1, 1, 18'h00B00, 0, 0, 0);
    vec[9]  = mk(1, 1, 18'h00B01, 18'h00C02, 4'h8, 0, 0,  1, 0, 1, 18'h00C01, 0, 0, 0);
    vec[10] = mk(0, 0, 18'h0,     18'h0,     4'h8, 0, 0,  0, 0, 1, 18'h00B01, 0, 0, 0);
    vec[11] = mk(1, 0, 18'h00D00, 18'h0,     4'h0, 0, 0,  0, 0, 0, 18'h00B01, 0, 0, 0);
    vec[12] = mk(1, 0, 18'h00D00, 18'h0,     4'h0, 0, 0,  0, 0, 0, 18'h00B01, 0, 0, 0);
    vec[13] = mk(1, 0, 18'h00D00, 18'h0,     4'h1, 1, 0,  1, 0, 0, 18'h00B01, 0, 0, 0);
    vec[14] = mk(1, 0, 18'h00D01, 18'h0,     4'h1, 1, 0,  0, 0, 1, 18'h00D00, 0, 0, 0);
    vec[15] = mk(1, 0, 18'h00D01, 18'h0,     4'h1, 1, 0,  1, 0, 0, 18'h00D00, 0, 0, 0);
    vec[16] = mk(1, 0, 18'h00D02, 18'h0,     4'h1, 1, 0,  0, 0, 1, 18'h00D01, 0, 0, 0);
    vec[17] = mk(1, 0, 18'h00E00, 18'h0,     4'h8, 0, 0,  1, 0, 0, 18'h00D01, 0, 0, 0);
    // flush wins over both requesters; the push granted last cycle still lands
    vec[18] = mk(1, 1, 18'h00E01, 18'h00C03, 4'h8, 0, 1,  0, 0, 1, 18'h00E00, 0, 0, 0);
    vec[19] = mk(1, 1, 18'h00E01, 18'h00C03, 4'h8, 0, 0,  0, 0, 0, 18'h00E00, 1, 1, 0);
    vec[20] = mk(1, 1, 18'h00E01, 18'h00C03, 4'h8, 0, 1,  0, 0, 0, 18'h00E00, 1, 1, 0);
    vec[21] = mk(1, 1, 18'h00E01, 18'h00C03, 4'h8, 0, 0,  0, 0, 0, 18'h00E00, 1, 1, 0);
    vec[22] = mk(1, 1, 18'h00E01, 18'h00C03, 4'h8, 0, 0,  0, 0, 0, 18'h00E00, 1, 1, 0);
    vec[23] = mk(1, 1, 18'h00E01, 18'h00C03, 4'h8, 0, 0,  0, 0, 0, 18'h00E00, 1, 0, 0);
    vec[24] = mk(1, 1, 18'h00E01, 18'h00C03, 4'h8, 0, 0,  0, 0, 0, 18'h00E00, 1, 0, 0);
    vec[25] = mk(1, 1, 18'h00E01, 18'h00C03, 4'h8, 0, 0,  0, 1, 0, 18'h00E00, 0, 0, 1);
    vec[26] = mk(1, 1, 18'h00E01, 18'h00C04, 4'h8, 0, 0,  1, 0, 1, 18'h00C03, 0, 0, 0);
    vec[27] = mk(0, 0, 18'h0,     18'h0,     4'h8, 0, 0,  0, 0, 1, 18'h00E01, 0, 0, 0);
    vec[28] = mk(0, 0, 18'h0,     18'h0,     4'h8, 0, 0,  0, 0, 0, 18'h00E01, 0, 0, 0);

    // reset state, with a request asserted to confirm grants stay low
    idle_inputs();
    Rst_n = 0;
    Req0 = 1; Req1 = 1;
    #12;
    chk("rst_gnt0", 32'(Gnt0), 32'd0);
    chk("rst_gnt1", 32'(Gnt1), 32'd0);
    chk("rst_push", 32'(PUSH), 32'd0);
    chk("rst_din", 32'(DIN), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_fpf", 32'(Fifo_Push_Flush), 32'd0);
    chk("rst_done", 32'(Flush_Done), 32'd0);
    chk("rst_pcnt", 32'(Push_Count), 32'd0);
    chk("rst_scnt", 32'(Stall_Count), 32'd0);

    @(negedge Clk);
    Rst_n = 1;
    for (int i = 0; i < 29; i++) begin
      Req0 = vec[i].r0; Req1 = vec[i].r1; Din0 = vec[i].d0; Din1 = vec[i].d1;
      PUSH_FLAG = vec[i].flag; Almost_Full = vec[i].af; Flush_Req = vec[i].fl;
      #1;
      chk($sformatf("v%0d_gnt0", i), 32'(Gnt0), 32'(vec[i].g0));
      chk($sformatf("v%0d_gnt1", i), 32'(Gnt1), 32'(vec[i].g1));
      chk($sformatf("v%0d_push", i), 32'(PUSH), 32'(vec[i].push));
      chk($sformatf("v%0d_din", i), 32'(DIN), 32'(vec[i].din));
      chk($sformatf("v%0d_busy", i), 32'(Busy), 32'(vec[i].busy));
      chk($sformatf("v%0d_fpf", i), 32'(Fifo_Push_Flush), 32'(vec[i].fpf));
      chk($sformatf("v%0d_done", i), 32'(Flush_Done), 32'(vec[i].done));
      @(negedge Clk);
    end

    // reset asserted in the second FLUSH cycle, then a lone Req1 right after release
    idle_inputs();
    do_reset();
    Flush_Req = 1;
    @(negedge Clk);
    Flush_Req = 0;
    @(negedge Clk);
    chk("mid_flush_fpf", 32'(Fifo_Push_Flush), 32'd1);
    Req0 = 1;
    #2 Rst_n = 0;
    #1;
    chk("rst_in_flush_fpf", 32'(Fifo_Push_Flush), 32'd0);
    chk("rst_in_flush_busy", 32'(Busy), 32'd0);
    chk("rst_in_flush_gnt0", 32'(Gnt0), 32'd0);
    @(negedge Clk);
    Rst_n = 1; Req0 = 0; Req1 = 1; Din1 = 18'h00F00;
    #1;
    chk("post_rst_gnt1", 32'(Gnt1), 32'd1);
    @(negedge Clk);
    Req1 = 0;
    #1;
    chk("post_rst_push", 32'(PUSH), 32'd1);
    chk("post_rst_din", 32'(DIN), 32'h00F00);

    // statistics: stalls on a full FIFO, then a long push run
    idle_inputs();
    do_reset();
    Req0 = 1; Din0 = 18'h00123; PUSH_FLAG = 4'h0;
    repeat (5) @(negedge Clk);
`ifdef FIFO_PUSH_ARB_STATS_EN
    exp_stall = 16'd5;
    n = 70000;
    exp_push = 16'hFFFF;
`else
    exp_stall = 16'd0;
    n = 200;
    exp_push = 16'd0;
`endif
    chk("stall_count", 32'(Stall_Count), 32'(exp_stall));
    PUSH_FLAG = 4'h8;
    repeat (n) @(negedge Clk);
    Req0 = 0;
    @(negedge Clk);
    chk("push_count", 32'(Push_Count), 32'(exp_push));
    chk("stall_count_hold", 32'(Stall_Count), 32'(exp_stall));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_push_arb.md
FIFO_PUSH_ARB -- requirements
Module: fifo_push_arb

Interface
Parameters:
- REQ-001 SHALL have parameter DATA_WIDTH, default 18, giving the width of the requester and FIFO data words (1..36).
- REQ-002 SHALL have parameter FLUSH_CYCLES, default 4, giving the number of cycles Fifo_Push_Flush is held high (2..15).

Ports (name, direction, width, meaning):
- REQ-003 SHALL have: Clk, in, 1, single clock; all logic is rising-edge; the FIFO push clock is driven from this same clock.
- REQ-004 SHALL have: Rst_n, in, 1, reset, asynchronous and active-low.
- REQ-005 SHALL have: Req0, in, 1, requester 0 push request; Din0, in, DATA_WIDTH, requester 0 data; Gnt0, out, 1, requester 0 word accepted.
- REQ-006 SHALL have: Req1, in, 1, requester 1 push request; Din1, in, DATA_WIDTH, requester 1 data; Gnt1, out, 1, requester 1 word accepted.
- REQ-007 SHALL have: Flush_Req, in, 1, flush request pulse; Flush_Done, out, 1, flush complete pulse; Busy, out, 1, high while not in RUN.
- REQ-008 SHALL have the FIFO side: PUSH, out, 1; DIN, out, DATA_WIDTH; Fifo_Push_Flush, out, 1; PUSH_FLAG, in, 4 (4'h0 = full); Almost_Full, in, 1.
- REQ-009 SHALL have: Push_Count, out, 16, words pushed; Stall_Count, out, 16, request cycles with no grant.

Function
- REQ-010 SHALL implement FSM states RUN, FLUSH and RECOVER, and leave reset in RUN.
- REQ-011 SHALL, in RUN, define "space" as PUSH_FLAG!=4'h0 AND NOT (Almost_Full AND PUSH registered high last cycle).
- REQ-012 SHALL, in RUN with space and Flush_Req low, grant exactly one asserted requester per cycle: Gnt is combinational in the cycle the request is taken.
- REQ-013 SHALL register the granted Din into DIN and assert PUSH on the next cycle (latency 1); PUSH SHALL be low in all other cycles.
- REQ-014 SHALL arbitrate round-robin: when both Req0 and Req1 are high, grant the requester not granted most recently; the pointer SHALL favour requester 0 after reset; a single requester SHALL be granted every cycle while it requests and there is space.
- REQ-015 SHALL hold Req and Din stable at the requester until Gnt; a dropped Req SHALL simply not be granted.
- REQ-016 SHALL, without space, grant nothing and hold PUSH low.
- REQ-017 SHALL, on Flush_Req in RUN, move to FLUSH; in that cycle flush takes priority over any grant.
- REQ-018 SHALL, in FLUSH, hold Fifo_Push_Flush high for exactly FLUSH_CYCLES cycles, then move to RECOVER.
- REQ-019 SHALL, in RECOVER, wait 2 cycles for the FIFO flags to settle, then return to RUN and pulse Flush_Done for 1 cycle on entry to RUN.
- REQ-020 SHALL ignore Flush_Req and all Req inputs, issuing no Gnt, while in FLUSH or RECOVER.
- REQ-021 SHALL still complete a PUSH registered in the cycle before FLUSH entry; Fifo_Push_Flush is first asserted in the following cycle.
- REQ-022 SHALL drive Busy=1 in FLUSH and RECOVER and Busy=0 in RUN.

Reset
- REQ-023 SHALL, on Rst_n low (asynchronous, at any state including mid-flush), set state=RUN, PUSH=0, DIN=0, Fifo_Push_Flush=0, Flush_Done=0, Busy=0, RR pointer=requester 0, Push_Count=0, Stall_Count=0.
- REQ-024 SHALL keep Gnt0 and Gnt1 at 0 while Rst_n is low.
- REQ-025 SHALL allow grants from the first rising edge after Rst_n deasserts.

Configuration
- REQ-026 SHALL, with FIFO_PUSH_ARB_STATS_EN defined, increment Push_Count on each PUSH cycle and Stall_Count on each RUN cycle with (Req0|Req1) high and no Gnt.
- REQ-027 SHALL make both counters 16-bit and saturating at 16'hFFFF.
- REQ-028 SHALL, without FIFO_PUSH_ARB_STATS_EN, tie Push_Count and Stall_Count to 0 and synthesize no counter logic.

Verification
- REQ-029 SHALL cover: Req0 only, PUSH_FLAG=4'h8 for 4 cycles -> Gnt0 in 4 cycles, PUSH high in cycles 2..5, DIN=Din0 each cycle.
- REQ-030 SHALL cover: Req0=Req1=1 continuously after reset -> grants 0,1,0,1; DIN alternates Din0/Din1.
- REQ-031 SHALL cover: PUSH_FLAG=4'h0 -> no Gnt, PUSH=0, Stall_Count increments per cycle (macro defined); PUSH_FLAG=4'h1 with Almost_Full=1 -> grants alternate with no-grant cycles.
- REQ-032 SHALL cover: Flush_Req pulse with both Req high, FLUSH_CYCLES=4 -> Fifo_Push_Flush high 4 cycles, Busy high 6 cycles, Flush_Done pulses 1 cycle, no Gnt until then.
- REQ-033 SHALL cover: Rst_n low at cycle 2 of FLUSH -> Fifo_Push_Flush=0 and Busy=0 immediately; after release, Req1 alone -> Gnt1 on the first edge.
- REQ-034 SHALL cover: 70000 pushes with the macro defined -> Push_Count=16'hFFFF; without the macro -> Push_Count=0.
